// File: rtl/fsm_shot_sequencer.sv
// ---------------------------------------------------------------------------
// fsm_shot_sequencer
//   Supervisor that runs fsm_experiment_phase through a programmed number of
//   shots. It raises exp_start for each shot and waits for the experiment to
//   report DETECTOR_FINISHED. Once the experiment is back in IDLE it waits an
//   inter-shot holdoff and then starts the next shot. A per-shot timeout or a
//   host abort pulses exp_reset and drains the experiment back to IDLE.
//
// Ports
//   clock            system clock
//   reset_signal     asynchronous active-low reset
//   cmd_start        1-cycle pulse: latch cfg_*, begin a sequence (IDLE only)
//   cmd_abort        1-cycle pulse: abort the running sequence
//   cfg_shots        shots per sequence; 0 = run until abort
//   cfg_timeout      max cycles per shot in ARM+RUN; 0 = no timeout
//   cfg_holdoff      extra idle cycles between shots
//   exp_state        experiment scenario_state (bits [3:0] used)
//   exp_start        start_signal to the experiment
//   exp_reset        reset_signal to the experiment (high during ABORT)
//   busy             high in every state except S_IDLE
//   shot_done        1-cycle pulse per completed shot
//   seq_done         1-cycle pulse when cfg_shots shots have completed
//   err_timeout      sticky timeout flag, cleared by an accepted cmd_start
//   shots_completed  shots finished in the current sequence (wraps)
//   seq_state        current sequencer state code
// ---------------------------------------------------------------------------
module fsm_shot_sequencer #(
    parameter int unsigned SHOTS_W       = 16,
    parameter int unsigned CNT_W         = 32,
    parameter logic [3:0]  EXP_IDLE      = 4'd0,
    parameter logic [3:0]  EXP_DONE      = 4'd10,
    parameter int unsigned RST_PULSE_LEN = 4
) (
    input  logic               clock,
    input  logic               reset_signal,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [SHOTS_W-1:0] cfg_shots,
    input  logic [CNT_W-1:0]   cfg_timeout,
    input  logic [CNT_W-1:0]   cfg_holdoff,
    input  logic [7:0]         exp_state,
    output logic               exp_start,
    output logic               exp_reset,
    output logic               busy,
    output logic               shot_done,
    output logic               seq_done,
    output logic               err_timeout,
    output logic [SHOTS_W-1:0] shots_completed,
    output logic [2:0]         seq_state
);

    localparam int unsigned RC_W = $clog2(RST_PULSE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_HOLDOFF = 3'd4,
        S_ABORT   = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t             r_state;
    logic [SHOTS_W-1:0] r_cfg_shots;
    logic [CNT_W-1:0]   r_cfg_timeout;
    logic [CNT_W-1:0]   r_cfg_holdoff;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [RC_W-1:0]    r_rst_cnt;
    logic [SHOTS_W-1:0] r_shots_completed;
    logic               r_exp_start;
    logic               r_exp_reset;
    logic               r_busy;
    logic               r_shot_done;
    logic               r_seq_done;
    logic               r_err_timeout;

    state_t             w_nxt_state;
    logic               w_exp_idle;
    logic               w_exp_done;
    logic               w_tmo_hit;
    logic               w_last_shot;
    logic               w_unused;

    // Only the low nibble of the experiment state carries the state code.
    assign w_unused   = ^exp_state[7:4];
    assign w_exp_idle = (exp_state[3:0] == EXP_IDLE);
    assign w_exp_done = (exp_state[3:0] == EXP_DONE);
    assign w_tmo_hit  = (r_cfg_timeout != '0) &&
                        (r_tmo_cnt == r_cfg_timeout - CNT_W'(1));
    assign w_last_shot = (r_cfg_shots != '0) &&
                         (r_shots_completed == r_cfg_shots);

    // Transition decision. Abort is tested first so it beats any other
    // transition in the same cycle; DONE is tested before the timeout so a
    // shot finishing on the expiry cycle still counts.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_start && !cmd_abort)
                    w_nxt_state = S_ARM;
            end
            S_ARM: begin
                if (cmd_abort)
                    w_nxt_state = S_ABORT;
                else if (!w_exp_idle)
                    w_nxt_state = S_RUN;
                else if (w_tmo_hit)
                    w_nxt_state = S_ABORT;
            end
            S_RUN: begin
                if (cmd_abort)
                    w_nxt_state = S_ABORT;
                else if (w_exp_done)
                    w_nxt_state = S_RELEASE;
                else if (w_tmo_hit)
                    w_nxt_state = S_ABORT;
            end
            S_RELEASE: begin
                if (cmd_abort)
                    w_nxt_state = S_ABORT;
                else if (w_exp_idle)
                    w_nxt_state = w_last_shot ? S_IDLE : S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (cmd_abort)
                    w_nxt_state = S_ABORT;
                else if (r_hold_cnt >= r_cfg_holdoff)
                    w_nxt_state = S_ARM;
            end
            S_ABORT: begin
                if (r_rst_cnt == RC_W'(RST_PULSE_LEN - 1))
                    w_nxt_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_exp_idle)
                    w_nxt_state = S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State, counters and registered outputs. Outputs are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            r_state           <= S_IDLE;
            r_cfg_shots       <= '0;
            r_cfg_timeout     <= '0;
            r_cfg_holdoff     <= '0;
            r_tmo_cnt         <= '0;
            r_hold_cnt        <= '0;
            r_rst_cnt         <= '0;
            r_shots_completed <= '0;
            r_exp_start       <= 1'b0;
            r_exp_reset       <= 1'b0;
            r_busy            <= 1'b0;
            r_shot_done       <= 1'b0;
            r_seq_done        <= 1'b0;
            r_err_timeout     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_exp_start <= (w_nxt_state == S_ARM) || (w_nxt_state == S_RUN);
            r_exp_reset <= (w_nxt_state == S_ABORT);
            r_busy      <= (w_nxt_state != S_IDLE);
            r_shot_done <= 1'b0;
            r_seq_done  <= 1'b0;

            if ((w_nxt_state == S_ABORT) && (r_state != S_ABORT))
                r_rst_cnt <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_nxt_state == S_ARM) begin
                        r_cfg_shots       <= cfg_shots;
                        r_cfg_timeout     <= cfg_timeout;
                        r_cfg_holdoff     <= cfg_holdoff;
                        r_shots_completed <= '0;
                        r_err_timeout     <= 1'b0;
                        r_tmo_cnt         <= '0;
                    end
                end
                S_ARM, S_RUN: begin
                    r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    if ((r_state == S_RUN) && (w_nxt_state == S_RELEASE)) begin
                        r_shot_done       <= 1'b1;
                        r_shots_completed <= r_shots_completed + SHOTS_W'(1);
                    end
                    // A host abort leaves the error flag alone.
                    if ((w_nxt_state == S_ABORT) && !cmd_abort)
                        r_err_timeout <= 1'b1;
                end
                S_RELEASE: begin
                    if (w_nxt_state == S_IDLE)
                        r_seq_done <= 1'b1;
                    else if (w_nxt_state == S_HOLDOFF)
                        r_hold_cnt <= '0;
                end
                S_HOLDOFF: begin
                    r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    if (w_nxt_state == S_ARM)
                        r_tmo_cnt <= '0;
                end
                S_ABORT: begin
                    r_rst_cnt <= r_rst_cnt + RC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign exp_start       = r_exp_start;
    assign exp_reset       = r_exp_reset;
    assign busy            = r_busy;
    assign shot_done       = r_shot_done;
    assign seq_done        = r_seq_done;
    assign err_timeout     = r_err_timeout;
    assign shots_completed = r_shots_completed;
    assign seq_state       = r_state;

endmodule

// File: tb/tb_fsm_shot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fsm_shot_sequencer
//   Directed bench for fsm_shot_sequencer paired with a small scenario_state
//   model of the experiment. Expected shot counts are queued when a sequence
//   is started and compared as shot_done / seq_done pulses appear.
// ---------------------------------------------------------------------------
module tb_fsm_shot_sequencer;

    localparam int SW = 4;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset_signal = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [SW-1:0] cfg_shots = '0;
    logic [CW-1:0] cfg_timeout = '0;
    logic [CW-1:0] cfg_holdoff = '0;
    logic [7:0]    exp_state;
    logic          exp_start;
    logic          exp_reset;
    logic          busy;
    logic          shot_done;
    logic          seq_done;
    logic          err_timeout;
    logic [SW-1:0] shots_completed;
    logic [2:0]    seq_state;

    always #5 clock = ~clock;

    fsm_shot_sequencer #(
        .SHOTS_W      (SW),
        .CNT_W        (CW),
        .EXP_IDLE     (4'd0),
        .EXP_DONE     (4'd10),
        .RST_PULSE_LEN(4)
    ) dut (
        .clock          (clock),
        .reset_signal   (reset_signal),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cfg_shots      (cfg_shots),
        .cfg_timeout    (cfg_timeout),
        .cfg_holdoff    (cfg_holdoff),
        .exp_state      (exp_state),
        .exp_start      (exp_start),
        .exp_reset      (exp_reset),
        .busy           (busy),
        .shot_done      (shot_done),
        .seq_done       (seq_done),
        .err_timeout    (err_timeout),
        .shots_completed(shots_completed),
        .seq_state      (seq_state)
    );

    // Experiment model: leaves IDLE one cycle after exp_start, reports DONE
    // (10) m_lat cycles later, returns to IDLE when exp_start drops or
    // exp_reset is high. m_en=0 keeps it in IDLE forever.
    logic       m_en = 1'b1;
    int         m_lat = 50;
    logic [3:0] m_state = 4'd0;
    int         m_cnt = 0;

    always @(posedge clock) begin
        if (!m_en || exp_reset || !exp_start) begin
            m_state <= 4'd0;
            m_cnt   <= 0;
        end else if (m_state == 4'd0) begin
            m_state <= 4'd1;
            m_cnt   <= 1;
        end else if (m_cnt == m_lat) begin
            m_state <= 4'd10;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Upper nibble is junk the DUT must ignore.
    assign exp_state = {4'h5, m_state};

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard and pulse monitors
    int   exp_shot_q[$];
    int   exp_seq_q[$];
    int   n_shots = 0;
    int   n_seq = 0;
    int   rst_run = 0;
    int   last_rst_len = 0;
    int   low_run = 0;
    int   min_gap = 1000;
    logic prev_start = 1'b0;

    always @(posedge clock) begin
        #1;
        if (shot_done === 1'b1) begin
            n_shots++;
            chk("shot_expected", exp_shot_q.size() != 0, 1);
            if (exp_shot_q.size() != 0)
                chk("shot_count", shots_completed, exp_shot_q.pop_front());
        end
        if (seq_done === 1'b1) begin
            n_seq++;
            chk("seq_expected", exp_seq_q.size() != 0, 1);
            if (exp_seq_q.size() != 0)
                chk("seq_count", shots_completed, exp_seq_q.pop_front());
        end
        if (exp_reset === 1'b1) begin
            rst_run++;
        end else if (rst_run != 0) begin
            last_rst_len = rst_run;
            rst_run = 0;
        end
        if (exp_start === 1'b1) begin
            if (!prev_start && low_run > 0 && low_run < min_gap)
                min_gap = low_run;
            low_run = 0;
        end else if (busy === 1'b1) begin
            low_run++;
        end else begin
            low_run = 0;
        end
        prev_start = exp_start;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (seq_state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, seq_state, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seq0;
        int shots0;

        // Reset
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs",
            {exp_start, exp_reset, busy, shot_done, seq_done, err_timeout, shots_completed, seq_state}, 0);
        @(negedge clock);
        reset_signal = 1'b1;
        tick();

        // 3 shots, holdoff 10, no timeout
        m_en = 1'b1; m_lat = 50;
        cfg_shots = 4'd3; cfg_holdoff = 10; cfg_timeout = 0;
        exp_shot_q.push_back(1); exp_shot_q.push_back(2); exp_shot_q.push_back(3);
        exp_seq_q.push_back(3);
        seq0 = n_seq;
        min_gap = 1000;
        pulse_start();
        chk("t1_arm_state", seq_state, 3'd1);
        chk("t1_exp_start", exp_start, 1);
        cfg_shots = 4'd7;   // must not affect the running sequence
        wait_state(3'd0, 2000, "t1_back_idle");
        chk("t1_shots", shots_completed, 3);
        chk("t1_seq_pulses", n_seq - seq0, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_gap_ge_11", min_gap >= 11, 1);
        chk("t1_queue_empty", exp_shot_q.size() + exp_seq_q.size(), 0);

        // Timeout with an experiment that never leaves IDLE
        m_en = 1'b0;
        cfg_shots = 4'd1; cfg_timeout = 100; cfg_holdoff = 0;
        seq0 = n_seq;
        pulse_start();
        n = 0;
        while (err_timeout !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t2_timeout_cycle", n, 100);
        chk("t2_abort_state", seq_state, 3'd5);
        wait_state(3'd0, 50, "t2_back_idle");
        chk("t2_rst_len", last_rst_len, 4);
        chk("t2_err_sticky", err_timeout, 1);
        chk("t2_no_seq_done", n_seq - seq0, 0);

        // Abort during holdoff of shot 2 of 5
        m_en = 1'b1; m_lat = 10;
        cfg_shots = 4'd5; cfg_timeout = 0; cfg_holdoff = 30;
        exp_shot_q.push_back(1); exp_shot_q.push_back(2);
        seq0 = n_seq;
        last_rst_len = 0;
        pulse_start();
        chk("t3_err_cleared", err_timeout, 0);
        n = 0;
        while (!(shots_completed === 4'd2 && seq_state === 3'd4) && n < 2000) begin
            tick();
            n++;
        end
        chk("t3_in_holdoff", seq_state, 3'd4);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("t3_abort_state", seq_state, 3'd5);
        wait_state(3'd0, 50, "t3_back_idle");
        chk("t3_shots", shots_completed, 2);
        chk("t3_err", err_timeout, 0);
        chk("t3_rst_len", last_rst_len, 4);
        chk("t3_no_seq_done", n_seq - seq0, 0);
        chk("t3_queue_empty", exp_shot_q.size(), 0);

        // DONE on the timeout expiry cycle: shot counts
        m_lat = 20;
        cfg_shots = 4'd1; cfg_timeout = 22; cfg_holdoff = 0;
        exp_shot_q.push_back(1);
        exp_seq_q.push_back(1);
        pulse_start();
        wait_state(3'd0, 500, "t4_back_idle");
        chk("t4_err", err_timeout, 0);
        chk("t4_shots", shots_completed, 1);

        // One cycle tighter: timeout wins
        cfg_timeout = 21;
        seq0 = n_seq;
        pulse_start();
        wait_state(3'd0, 500, "t4b_back_idle");
        chk("t4b_err", err_timeout, 1);
        chk("t4b_shots", shots_completed, 0);
        chk("t4b_no_seq_done", n_seq - seq0, 0);

        // Continuous mode, 20 fast shots, counter wraps
        m_lat = 1;
        cfg_shots = 4'd0; cfg_timeout = 0; cfg_holdoff = 0;
        for (int i = 0; i < 20; i++) exp_shot_q.push_back((i + 1) % 16);
        seq0 = n_seq;
        shots0 = n_shots;
        pulse_start();
        n = 0;
        while (n_shots - shots0 < 20 && n < 3000) begin
            tick();
            n++;
        end
        chk("t5_twenty_shots", n_shots - shots0, 20);
        chk("t5_busy", busy, 1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_state(3'd0, 50, "t5_back_idle");
        chk("t5_shots_wrapped", shots_completed, 4);
        chk("t5_no_seq_done", n_seq - seq0, 0);
        chk("t5_queue_empty", exp_shot_q.size(), 0);

        // Asynchronous reset in S_RUN
        m_lat = 50;
        cfg_shots = 4'd1;
        pulse_start();
        wait_state(3'd2, 50, "t6_in_run");
        #2;
        reset_signal = 1'b0;
        #1;
        chk("t6_async_reset",
            {exp_start, exp_reset, busy, shot_done, seq_done, err_timeout, shots_completed, seq_state}, 0);
        @(negedge clock);
        reset_signal = 1'b1;
        tick();
        chk("t6_idle_after_reset", seq_state, 3'd0);

        // start and abort together in S_IDLE
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk("t7_stay_idle", seq_state, 3'd0);
        chk("t7_not_busy", busy, 0);
        tick();
        chk("t7_exp_start_low", exp_start, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
